// File: rtl/dmc_cache_ctrl.sv
// Direct-mapped, 256-line, 16-bit cache controller in front of main memory.
// Read misses fill the line from memory. Writes go through to memory and
// update the cache only on a hit; a write miss does not allocate a line.
// The memory side uses a level strobe that is held until mem_ack.
// Read hit and read miss counters saturate at CNT_MAX.
module dmc_cache_ctrl #(
    parameter int          ADDR_W  = 12,
    parameter int          DATA_W  = 16,
    parameter int          INDEX_W = 8,
    parameter logic [15:0] CNT_MAX = 16'hFFFF
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              cpu_ready,
    output logic              cache_hit,
    input  logic              flush,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_dout,
    input  logic [DATA_W-1:0] mem_din,
    input  logic              mem_ack,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
);
    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_FILL   = 3'd2,
        S_WRITE  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Saturating increment: a counter that has reached CNT_MAX stays there.
    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        if (value >= CNT_MAX) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [DATA_W-1:0]  data_mem [LINES];
    logic [LINES-1:0]   valid_r;

    state_t             state_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [DATA_W-1:0]  din_r;
    logic               wr_r;
    logic               hit_flag_r;

    logic [INDEX_W-1:0] idx_s;
    logic [TAG_W-1:0]   tag_s;
    logic               hit_s;
    logic [DATA_W-1:0]  line_data_s;
    logic               fill_en_s;
    logic               wr_hit_en_s;

    // Decode the latched request against the selected line.
    always_comb begin
        idx_s       = addr_r[INDEX_W-1:0];
        tag_s       = addr_r[ADDR_W-1:INDEX_W];
        hit_s       = valid_r[idx_s] && (tag_mem[idx_s] == tag_s);
        line_data_s = data_mem[idx_s];
        // mem_ack is meaningful only while the read strobe is up.
        fill_en_s   = (state_r == S_FILL) && mem_rd && mem_ack;
        wr_hit_en_s = (state_r == S_LOOKUP) && wr_r && hit_s;
    end

    // Tag and data storage. These arrays are not reset; valid_r qualifies them.
    always_ff @(posedge clk) begin
        if (fill_en_s) begin
            data_mem[idx_s] <= mem_din;
            tag_mem[idx_s]  <= tag_s;
        end else if (wr_hit_en_s) begin
            data_mem[idx_s] <= din_r;
        end
    end

    // Controller FSM with registered CPU and memory outputs, valid bits and counters.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r    <= S_IDLE;
            valid_r    <= '0;
            addr_r     <= '0;
            din_r      <= '0;
            wr_r       <= 1'b0;
            hit_flag_r <= 1'b0;
            cpu_dout   <= '0;
            cpu_ready  <= 1'b0;
            cache_hit  <= 1'b0;
            mem_addr   <= '0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_dout   <= '0;
            hit_cnt    <= 16'd0;
            miss_cnt   <= 16'd0;
        end else begin
            cpu_ready <= 1'b0;
            cache_hit <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    // The cycle that carries the cpu_ready pulse still belongs
                    // to the previous request, so nothing new is taken then.
                    if (!cpu_ready) begin
                        if (flush) begin
                            valid_r <= '0;
                        end else if (cpu_rd || cpu_wr) begin
                            addr_r  <= cpu_addr;
                            din_r   <= cpu_din;
                            // A simultaneous read and write is treated as a write.
                            wr_r    <= cpu_wr;
                            state_r <= S_LOOKUP;
                        end
                    end
                end
                S_LOOKUP: begin
                    if (wr_r) begin
                        hit_flag_r <= 1'b0;
                        mem_wr     <= 1'b1;
                        mem_addr   <= addr_r;
                        mem_dout   <= din_r;
                        state_r    <= S_WRITE;
                    end else if (hit_s) begin
                        hit_flag_r <= 1'b1;
                        cpu_dout   <= line_data_s;
                        hit_cnt    <= sat_inc(hit_cnt);
                        state_r    <= S_DONE;
                    end else begin
                        hit_flag_r <= 1'b0;
                        mem_rd     <= 1'b1;
                        mem_addr   <= addr_r;
                        miss_cnt   <= sat_inc(miss_cnt);
                        state_r    <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (fill_en_s) begin
                        mem_rd         <= 1'b0;
                        cpu_dout       <= mem_din;
                        valid_r[idx_s] <= 1'b1;
                        state_r        <= S_DONE;
                    end
                end
                S_WRITE: begin
                    if (mem_wr && mem_ack) begin
                        mem_wr  <= 1'b0;
                        state_r <= S_DONE;
                    end
                end
                S_DONE: begin
                    cpu_ready <= 1'b1;
                    cache_hit <= hit_flag_r;
                    state_r   <= S_IDLE;
                end
                default: begin
                    mem_rd  <= 1'b0;
                    mem_wr  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmc_cache_ctrl.sv
// Self-checking bench for dmc_cache_ctrl. A table of directed vectors is
// followed by hand-written reset and flush sequences, then by randomized
// traffic that is checked against an array-based cache model.
// A second instance with a small counter limit checks counter saturation.
module tb_dmc_cache_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic [11:0] cpu_addr;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [15:0] cpu_din;
    logic        flush;
    logic [15:0] mem_din;
    logic        mem_ack;

    logic [15:0] cpu_dout, mem_dout, hit_cnt, miss_cnt;
    logic        cpu_ready, cache_hit, mem_rd, mem_wr;
    logic [11:0] mem_addr;

    logic [15:0] s_cpu_dout, s_mem_dout, s_hit_cnt, s_miss_cnt;
    logic        s_cpu_ready, s_cache_hit, s_mem_rd, s_mem_wr;
    logic [11:0] s_mem_addr;

    localparam int SAT_MAX = 5;

    dmc_cache_ctrl dut (
        .clk(clk), .clr(clr), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ready(cpu_ready), .cache_hit(cache_hit),
        .flush(flush), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_dout(mem_dout), .mem_din(mem_din), .mem_ack(mem_ack),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    dmc_cache_ctrl #(.CNT_MAX(16'd5)) dut_sat (
        .clk(clk), .clr(clr), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_din(cpu_din), .cpu_dout(s_cpu_dout), .cpu_ready(s_cpu_ready), .cache_hit(s_cache_hit),
        .flush(flush), .mem_addr(s_mem_addr), .mem_rd(s_mem_rd), .mem_wr(s_mem_wr),
        .mem_dout(s_mem_dout), .mem_din(mem_din), .mem_ack(mem_ack),
        .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [11:0] addr;
        logic [15:0] din;
        int          ack_d;
        logic [15:0] mdin;
        logic [15:0] exp_dout;
        bit          exp_hit;
        bit          exp_rd;
        bit          exp_wr;
        logic [15:0] exp_hcnt;
        logic [15:0] exp_mcnt;
    } vec_t;

    vec_t tbl [10];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: plain arrays indexed by line.
    bit   [255:0] m_valid;
    logic [3:0]   m_tag  [256];
    logic [15:0]  m_data [256];
    int           m_hits;
    int           m_misses;
    logic [15:0]  m_last;

    // Results of the most recent transaction.
    logic [15:0] r_dout, r_maddr, r_mdout, r_hcnt, r_mcnt, r_shcnt, r_smcnt;
    bit          r_hit, r_saw_rd, r_saw_wr, r_both, r_drop_bad, r_done;
    int          r_ready_k, r_ack_k;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid  = '0;
        m_hits   = 0;
        m_misses = 0;
        m_last   = 16'h0000;
    endtask

    // Apply the cache rules to the model and return the expected outcome.
    task automatic predict(input bit rd, input bit wr, input logic [11:0] a, input logic [15:0] d,
                           input int ack_d, input logic [15:0] md, output vec_t v);
        logic [7:0] idx;
        bit         hit;
        idx = a[7:0];
        hit = m_valid[idx] && (m_tag[idx] == a[11:8]);
        v.rd = rd; v.wr = wr; v.addr = a; v.din = d; v.ack_d = ack_d; v.mdin = md;
        v.exp_hit = 1'b0; v.exp_rd = 1'b0; v.exp_wr = 1'b0;
        if (wr) begin
            v.exp_wr = 1'b1;
            if (hit) m_data[idx] = d;
        end else if (hit) begin
            m_hits++;
            m_last = m_data[idx];
            v.exp_hit = 1'b1;
        end else begin
            m_misses++;
            m_valid[idx] = 1'b1;
            m_tag[idx]   = a[11:8];
            m_data[idx]  = md;
            m_last       = md;
            v.exp_rd     = 1'b1;
        end
        v.exp_dout = m_last;
        v.exp_hcnt = (m_hits   > 65535) ? 16'hFFFF : 16'(m_hits);
        v.exp_mcnt = (m_misses > 65535) ? 16'hFFFF : 16'(m_misses);
    endtask

    // Issue one request, play the memory side, and record what the DUT did.
    task automatic run_txn(input vec_t v);
        int scount;
        @(negedge clk);
        cpu_rd = v.rd; cpu_wr = v.wr; cpu_addr = v.addr; cpu_din = v.din;
        @(posedge clk);
        r_saw_rd = 0; r_saw_wr = 0; r_both = 0; r_drop_bad = 0; r_done = 0; r_hit = 0;
        r_ready_k = -1; r_ack_k = -1; scount = 0;
        for (int k = 1; k <= 60 && !r_done; k++) begin
            @(negedge clk);
            if (k == 1) begin
                cpu_rd = 1'b0; cpu_wr = 1'b0;
            end
            mem_ack = 1'b0;
            if (mem_rd && mem_wr) r_both = 1;
            if (mem_rd) r_saw_rd = 1;
            if (mem_wr) r_saw_wr = 1;
            if (r_ack_k > 0 && k == r_ack_k + 1 && (mem_rd || mem_wr)) r_drop_bad = 1;
            if (mem_rd || mem_wr) begin
                r_maddr = mem_addr;
                r_mdout = mem_dout;
                if (scount == v.ack_d) begin
                    mem_ack = 1'b1;
                    mem_din = v.mdin;
                    r_ack_k = k;
                end
                scount++;
            end
            if (cpu_ready) begin
                r_dout = cpu_dout; r_hit = cache_hit; r_ready_k = k;
                r_hcnt = hit_cnt; r_mcnt = miss_cnt; r_shcnt = s_hit_cnt; r_smcnt = s_miss_cnt;
                r_done = 1;
            end
        end
        mem_ack = 1'b0;
    endtask

    task automatic check_txn(input string tag, input vec_t v);
        chk({tag, ".done"}, 32'(r_done), 32'd1);
        chk({tag, ".both_strobes"}, 32'(r_both), 32'd0);
        chk({tag, ".strobe_drop"}, 32'(r_drop_bad), 32'd0);
        chk({tag, ".cpu_dout"}, 32'(r_dout), 32'(v.exp_dout));
        chk({tag, ".cache_hit"}, 32'(r_hit), 32'(v.exp_hit));
        chk({tag, ".mem_rd"}, 32'(r_saw_rd), 32'(v.exp_rd));
        chk({tag, ".mem_wr"}, 32'(r_saw_wr), 32'(v.exp_wr));
        if (v.exp_rd || v.exp_wr) begin
            chk({tag, ".mem_addr"}, 32'(r_maddr), 32'(v.addr));
            chk({tag, ".latency"}, 32'(r_ready_k), 32'(r_ack_k + 2));
        end else begin
            chk({tag, ".latency"}, 32'(r_ready_k), 32'd3);
        end
        if (v.exp_wr) chk({tag, ".mem_dout"}, 32'(r_mdout), 32'(v.din));
        chk({tag, ".hit_cnt"}, 32'(r_hcnt), 32'(v.exp_hcnt));
        chk({tag, ".miss_cnt"}, 32'(r_mcnt), 32'(v.exp_mcnt));
        chk({tag, ".sat_hit_cnt"}, 32'(r_shcnt),
            32'((v.exp_hcnt > 16'(SAT_MAX)) ? 16'(SAT_MAX) : v.exp_hcnt));
        chk({tag, ".sat_miss_cnt"}, 32'(r_smcnt),
            32'((v.exp_mcnt > 16'(SAT_MAX)) ? 16'(SAT_MAX) : v.exp_mcnt));
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        m_valid = '0;
    endtask

    initial begin
        vec_t        pv;
        bit          seen;
        bit          bad;
        logic [11:0] ra;
        bit          rrd, rwr;

        //           rd  wr  addr     din       ack mdin      dout      hit rd wr hcnt   mcnt
        tbl[0] = '{1'b1, 1'b0, 12'h123, 16'h0000, 3, 16'hBEEF, 16'hBEEF, 1'b0, 1'b1, 1'b0, 16'd0, 16'd1};
        tbl[1] = '{1'b1, 1'b0, 12'h123, 16'h0000, 0, 16'h0000, 16'hBEEF, 1'b1, 1'b0, 1'b0, 16'd1, 16'd1};
        tbl[2] = '{1'b1, 1'b0, 12'h223, 16'h0000, 1, 16'h5555, 16'h5555, 1'b0, 1'b1, 1'b0, 16'd1, 16'd2};
        tbl[3] = '{1'b1, 1'b0, 12'h123, 16'h0000, 0, 16'hBEEF, 16'hBEEF, 1'b0, 1'b1, 1'b0, 16'd1, 16'd3};
        tbl[4] = '{1'b0, 1'b1, 12'h123, 16'h1234, 2, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 1'b1, 16'd1, 16'd3};
        tbl[5] = '{1'b1, 1'b0, 12'h123, 16'h0000, 0, 16'h0000, 16'h1234, 1'b1, 1'b0, 1'b0, 16'd2, 16'd3};
        tbl[6] = '{1'b0, 1'b1, 12'h456, 16'h0AAA, 0, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b1, 16'd2, 16'd3};
        tbl[7] = '{1'b1, 1'b0, 12'h456, 16'h0000, 1, 16'h0AAA, 16'h0AAA, 1'b0, 1'b1, 1'b0, 16'd2, 16'd4};
        tbl[8] = '{1'b1, 1'b1, 12'h789, 16'h7777, 0, 16'h0000, 16'h0AAA, 1'b0, 1'b0, 1'b1, 16'd2, 16'd4};
        tbl[9] = '{1'b1, 1'b0, 12'h789, 16'h0000, 0, 16'h1111, 16'h1111, 1'b0, 1'b1, 1'b0, 16'd2, 16'd5};

        clr = 1'b0; cpu_addr = 12'h000; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_din = 16'h0000;
        flush = 1'b0; mem_din = 16'h0000; mem_ack = 1'b0;
        model_reset();

        repeat (2) @(negedge clk);
        chk("rst.cpu_ready", 32'(cpu_ready), 32'd0);
        chk("rst.cache_hit", 32'(cache_hit), 32'd0);
        chk("rst.cpu_dout", 32'(cpu_dout), 32'd0);
        chk("rst.mem_rd", 32'(mem_rd), 32'd0);
        chk("rst.mem_wr", 32'(mem_wr), 32'd0);
        chk("rst.mem_addr", 32'(mem_addr), 32'd0);
        chk("rst.hit_cnt", 32'(hit_cnt), 32'd0);
        chk("rst.miss_cnt", 32'(miss_cnt), 32'd0);
        clr = 1'b1;

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            predict(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].din, tbl[i].ack_d, tbl[i].mdin, pv);
            run_txn(tbl[i]);
            check_txn($sformatf("vec%0d", i), tbl[i]);
        end

        // Reset asserted while a fill is waiting for mem_ack.
        @(negedge clk);
        cpu_rd = 1'b1; cpu_addr = 12'h300;
        @(posedge clk);
        @(negedge clk);
        cpu_rd = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (mem_rd) seen = 1;
            else @(negedge clk);
        end
        chk("midfill.mem_rd_seen", 32'(seen), 32'd1);
        #2 clr = 1'b0;
        #1;
        chk("midfill.mem_rd_async", 32'(mem_rd), 32'd0);
        chk("midfill.miss_cnt_async", 32'(miss_cnt), 32'd0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (cpu_ready || mem_rd || mem_wr) bad = 1;
        end
        clr = 1'b1;
        model_reset();
        repeat (4) begin
            @(negedge clk);
            if (cpu_ready || mem_rd || mem_wr) bad = 1;
        end
        chk("midfill.no_completion", 32'(bad), 32'd0);
        chk("midfill.hit_cnt", 32'(hit_cnt), 32'd0);

        predict(1'b1, 1'b0, 12'h223, 16'h0000, 2, 16'h2222, pv);
        run_txn(pv);
        chk("postrst.miss", 32'(r_saw_rd), 32'd1);
        check_txn("postrst", pv);

        // Resident line, then flush, then the same address must miss.
        predict(1'b1, 1'b0, 12'h223, 16'h0000, 0, 16'h0000, pv);
        run_txn(pv);
        chk("preflush.hit", 32'(r_hit), 32'd1);
        check_txn("preflush", pv);
        do_flush();
        predict(1'b1, 1'b0, 12'h223, 16'h0000, 1, 16'h3333, pv);
        run_txn(pv);
        chk("postflush.miss", 32'(r_saw_rd), 32'd1);
        check_txn("postflush", pv);

        // Randomized traffic over a small address set so hits and conflicts occur.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) do_flush();
            ra  = {4'($urandom_range(0, 3)), 8'($urandom_range(0, 7))};
            rrd = ($urandom_range(0, 2) != 0);
            rwr = rrd ? ($urandom_range(0, 5) == 0) : 1'b1;
            predict(rrd, rwr, ra, 16'($urandom), $urandom_range(0, 3), 16'($urandom), pv);
            run_txn(pv);
            check_txn($sformatf("rnd%0d", n), pv);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
